// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives every input combination into a combinational primitive, waits a
// fixed settle time, samples the primitive's output and rebuilds its truth
// table. Each captured row is streamed over a valid/ready handshake and the
// whole table is exposed as a packed vector once the sweep completes.
// Every output comes straight from a flop; no input reaches an output
// combinationally.

module truth_table_sweeper #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [N_IN:0]          row_data,
  output logic [(1<<N_IN)-1:0]   table_bits
);

  // Table depth: one bit per input combination.
  localparam int ROWS = 1 << N_IN;

  // The settle counter only has to reach SETTLE_CYCLES-1, so a single bit
  // is enough when SETTLE_CYCLES is 1 or 2.
  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // idx is N_IN bits wide; the terminal compare against the all-ones value
  // happens before any increment, so the index never wraps.
  localparam logic [N_IN-1:0]  IDX_ZERO = N_IN'(32'd0);
  localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(32'd1);
  localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(ROWS - 1);

  localparam logic [ROWS-1:0]  TABLE_ZERO = ROWS'(32'd0);
  localparam logic [N_IN:0]    ROW_ZERO   = (N_IN + 1)'(32'd0);

  // FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [N_IN-1:0]  idx_q,       idx_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             row_valid_q, row_valid_d;
  logic [N_IN:0]    row_data_q,  row_data_d;
  logic [ROWS-1:0]  table_q,     table_d;

  // The applied vector is the row index itself; both live in idx_q so the
  // vector can never drift from the row being captured or emitted.
  assign dut_in     = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign row_valid  = row_valid_q;
  assign row_data   = row_data_q;
  assign table_bits = table_q;

  // Next-state logic for the sweep FSM and all of its registered outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    table_d     = table_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A new sweep discards the previous table and starts at vector 0.
          state_d = ST_DRIVE;
          idx_d   = IDX_ZERO;
          cnt_d   = CNT_ZERO;
          table_d = TABLE_ZERO;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          // End of settle: this is the only edge at which dut_out is
          // observed, so later glitches cannot corrupt the captured row.
          table_d[idx_q] = dut_out;
          row_data_d     = {idx_q, dut_out};
          row_valid_d    = 1'b1;
          cnt_d          = CNT_ZERO;
          state_d        = ST_EMIT;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_DRIVE;
        end
      end

      ST_EMIT: begin
        if (row_ready) begin
          row_valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            // Last row consumed: busy drops as done rises.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            cnt_d   = CNT_ZERO;
            state_d = ST_DRIVE;
          end
        end else begin
          // Backpressure: hold the row and the applied vector unchanged.
          state_d = ST_EMIT;
        end
      end

      ST_DONE: begin
        // One-cycle completion pulse; start is deliberately not sampled here
        // so a held start relaunches only from IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        idx_d       = IDX_ZERO;
        cnt_d       = CNT_ZERO;
        busy_d      = 1'b0;
        row_valid_d = 1'b0;
        row_data_d  = ROW_ZERO;
        table_d     = TABLE_ZERO;
      end
    endcase
  end

  // State and output registers; reset abandons any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_ZERO;
      cnt_q       <= CNT_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_valid_q <= 1'b0;
      row_data_q  <= ROW_ZERO;
      table_q     <= TABLE_ZERO;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      table_q     <= table_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (2-input AND/OR with a
// 2-cycle settle, 3-input majority with a 1-cycle settle). Stimulus pushes
// hand-computed rows and tables into queues; monitors pop and compare on
// each row handshake and each done pulse.

module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: N_IN=2, SETTLE_CYCLES=2
  logic       start_a, ready_a, glitch_a, or_mode_a;
  logic       busy_a, done_a, row_valid_a, dut_out_a;
  logic [1:0] dut_in_a;
  logic [2:0] row_data_a;
  logic [3:0] table_a;

  // Instance B: N_IN=3, SETTLE_CYCLES=1
  logic       start_b, ready_b;
  logic       busy_b, done_b, row_valid_b, dut_out_b;
  logic [2:0] dut_in_b;
  logic [3:0] row_data_b;
  logic [7:0] table_b;

  // Primitives under test; glitch_a lets the bench disturb the output
  // outside the sampling edge.
  assign dut_out_a = (or_mode_a ? (dut_in_a[0] | dut_in_a[1])
                                : (dut_in_a[0] & dut_in_a[1])) ^ glitch_a;
  assign dut_out_b = (dut_in_b[0] & dut_in_b[1]) | (dut_in_b[0] & dut_in_b[2]) |
                     (dut_in_b[1] & dut_in_b[2]);

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .row_valid(row_valid_a),
    .row_ready(ready_a), .row_data(row_data_a), .table_bits(table_a)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .row_valid(row_valid_b),
    .row_ready(ready_b), .row_data(row_data_b), .table_bits(table_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_rows_a[$];
  logic [7:0] exp_tab_a[$];
  logic [7:0] exp_rows_b[$];
  logic [7:0] exp_tab_b[$];
  logic [7:0] e_a, e_b;
  int rows_a = 0, dones_a = 0, rows_b = 0, dones_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  // Monitor A: compares every presented row against the queue head and
  // pops on handshake; pops the expected table on each done pulse.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (row_valid_a) begin
        if (exp_rows_a.size() == 0) begin
          flag("row_a_unexpected");
        end else begin
          e_a = exp_rows_a[0];
          check("row_a_data", 64'(row_data_a), 64'(e_a));
          check("row_a_dut_in", 64'(dut_in_a), 64'(e_a[7:1]));
          if (ready_a) begin
            void'(exp_rows_a.pop_front());
            rows_a++;
          end
        end
      end
      if (done_a) begin
        dones_a++;
        check("busy_a_in_done", 64'(busy_a), 64'd0);
        if (exp_tab_a.size() == 0) flag("done_a_unexpected");
        else check("table_a", 64'(table_a), 64'(exp_tab_a.pop_front()));
      end
    end
  end

  // Monitor B: same scheme for the 3-input instance.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (row_valid_b) begin
        if (exp_rows_b.size() == 0) begin
          flag("row_b_unexpected");
        end else begin
          e_b = exp_rows_b[0];
          check("row_b_data", 64'(row_data_b), 64'(e_b));
          check("row_b_dut_in", 64'(dut_in_b), 64'(e_b[7:1]));
          if (ready_b) begin
            void'(exp_rows_b.pop_front());
            rows_b++;
          end
        end
      end
      if (done_b) begin
        dones_b++;
        if (exp_tab_b.size() == 0) flag("done_b_unexpected");
        else check("table_b", 64'(table_b), 64'(exp_tab_b.pop_front()));
      end
    end
  end

  task automatic push_sweep_a(input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3,
                              input logic [7:0] tab);
    exp_rows_a.push_back(r0);
    exp_rows_a.push_back(r1);
    exp_rows_a.push_back(r2);
    exp_rows_a.push_back(r3);
    exp_tab_a.push_back(tab);
  endtask

  task automatic pulse_start_a(output int e0);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start_a = 1'b0;
  endtask

  task automatic wait_idx_a(input logic [1:0] v, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dut_in_a == v) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag(name);
  endtask

  task automatic wait_valid_a(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (row_valid_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag(name);
  endtask

  task automatic wait_done_a(input int max, input string name, output int at);
    bit got;
    got = 1'b0;
    at = -1;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done_a) begin
        got = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!got) flag(name);
  endtask

  // AND rows {idx, out}: 00->0, 01->0, 10->0, 11->1
  localparam logic [7:0] AND0 = 8'b000, AND1 = 8'b010, AND2 = 8'b100, AND3 = 8'b111;
  // OR rows: 00->0, 01->1, 10->1, 11->1
  localparam logic [7:0] OR0 = 8'b000, OR1 = 8'b011, OR2 = 8'b101, OR3 = 8'b111;
  // 3-input majority rows {idx, out}
  localparam logic [7:0] MAJ [8] = '{8'b0000, 8'b0010, 8'b0100, 8'b0111,
                                     8'b1000, 8'b1011, 8'b1101, 8'b1111};
  localparam logic [6:0] READY_PAT = 7'b1011001;

  int e0, at, at1, at2, r0, d0, nd;
  bit got;

  initial begin
    rst_n = 1'b1; start_a = 1'b0; ready_a = 1'b1; glitch_a = 1'b0; or_mode_a = 1'b0;
    start_b = 1'b0; ready_b = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_valid_a", 64'(row_valid_a), 64'd0);
    check("rst_dut_in_a", 64'(dut_in_a), 64'd0);
    check("rst_row_data_a", 64'(row_data_a), 64'd0);
    check("rst_table_a", 64'(table_a), 64'd0);
    check("rst_busy_b", 64'(busy_b), 64'd0);
    check("rst_table_b", 64'(table_b), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: AND sweep, ready tied high, latency
    push_sweep_a(AND0, AND1, AND2, AND3, 8'b1000);
    pulse_start_a(e0);
    @(negedge clk);
    check("t1_busy_after_start", 64'(busy_a), 64'd1);
    wait_done_a(200, "t1_done_timeout", at);
    check("t1_latency", 64'(at - e0), 64'd12);
    @(negedge clk);
    check("t1_done_single", 64'(done_a), 64'd0);
    check("t1_busy_idle", 64'(busy_a), 64'd0);
    check("t1_table_hold", 64'(table_a), 64'b1000);

    // 2: 5-cycle backpressure on row 2, dut_out glitched during EMIT
    push_sweep_a(AND0, AND1, AND2, AND3, 8'b1000);
    pulse_start_a(e0);
    wait_idx_a(2'd2, "t2_idx2_timeout");
    ready_a = 1'b0;
    wait_valid_a("t2_valid_timeout");
    glitch_a = 1'b1;
    repeat (5) @(negedge clk);
    glitch_a = 1'b0;
    ready_a = 1'b1;
    wait_done_a(200, "t2_done_timeout", at);
    check("t2_latency", 64'(at - e0), 64'd17);

    // 3: reset during DRIVE of row 1 (row 0 captured as 1 via glitch)
    repeat (2) @(negedge clk);
    exp_rows_a.push_back(8'b001);
    glitch_a = 1'b1;
    pulse_start_a(e0);
    wait_idx_a(2'd1, "t3_idx1_timeout");
    rst_n = 1'b0;
    #1;
    check("t3_rst_busy", 64'(busy_a), 64'd0);
    check("t3_rst_valid", 64'(row_valid_a), 64'd0);
    check("t3_rst_done", 64'(done_a), 64'd0);
    check("t3_rst_table", 64'(table_a), 64'd0);
    check("t3_rst_dut_in", 64'(dut_in_a), 64'd0);
    glitch_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_sweep_a(AND0, AND1, AND2, AND3, 8'b1000);
    pulse_start_a(e0);
    wait_done_a(200, "t3_done_timeout", at);
    check("t3_latency", 64'(at - e0), 64'd12);

    // 4: start re-asserted mid-sweep is ignored
    repeat (2) @(negedge clk);
    r0 = rows_a; d0 = dones_a;
    push_sweep_a(AND0, AND1, AND2, AND3, 8'b1000);
    pulse_start_a(e0);
    wait_idx_a(2'd2, "t4_idx2_timeout");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(200, "t4_done_timeout", at);
    repeat (30) @(negedge clk);
    check("t4_rows", 64'(rows_a - r0), 64'd4);
    check("t4_dones", 64'(dones_a - d0), 64'd1);
    check("t4_idle", 64'(busy_a), 64'd0);

    // 5: start held high, OR primitive, back-to-back sweeps
    or_mode_a = 1'b1;
    r0 = rows_a; d0 = dones_a;
    push_sweep_a(OR0, OR1, OR2, OR3, 8'b1110);
    push_sweep_a(OR0, OR1, OR2, OR3, 8'b1110);
    @(negedge clk);
    start_a = 1'b1;
    nd = 0; at1 = -1; at2 = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_a) begin
        nd++;
        if (nd == 1) at1 = cyc;
        else begin
          at2 = cyc;
          start_a = 1'b0;
          break;
        end
      end
    end
    if (nd < 2) begin
      start_a = 1'b0;
      flag("t5_done_timeout");
    end
    check("t5_gap", 64'(at2 - at1), 64'd14);
    repeat (30) @(negedge clk);
    check("t5_rows", 64'(rows_a - r0), 64'd8);
    check("t5_dones", 64'(dones_a - d0), 64'd2);
    check("t5_idle", 64'(busy_a), 64'd0);
    or_mode_a = 1'b0;

    // 6: 3-input majority, 1-cycle settle, irregular backpressure
    for (int i = 0; i < 8; i++) exp_rows_b.push_back(MAJ[i]);
    exp_tab_b.push_back(8'b11101000);
    ready_b = 1'b0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done_b) begin
        got = 1'b1;
        break;
      end
      ready_b = READY_PAT[k % 7];
      @(negedge clk);
    end
    ready_b = 1'b1;
    if (!got) flag("t6_done_timeout");
    repeat (5) @(negedge clk);
    check("t6_rows", 64'(rows_b), 64'd8);
    check("t6_dones", 64'(dones_b), 64'd1);
    check("t6_table_hold", 64'(table_b), 64'b11101000);

    // Every expectation consumed
    check("rows_a_left", 64'(exp_rows_a.size()), 64'd0);
    check("tabs_a_left", 64'(exp_tab_a.size()), 64'd0);
    check("rows_b_left", 64'(exp_rows_b.size()), 64'd0);
    check("tabs_b_left", 64'(exp_tab_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
